// File: rtl/regfile_2r1w.sv
// Parametrised 2-read / 1-write flop register file with optional read registers,
// write-to-read bypass and a hardwired-zero word 0.
module regfile_2r1w #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int READ_REG   = 0,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    input  logic [ADDR_WIDTH-1:0] Write_Address,
    input  logic                  Write_Enable,
    input  logic [ADDR_WIDTH-1:0] Read_Address_1,
    input  logic                  Read_Enable_1,
    input  logic [ADDR_WIDTH-1:0] Read_Address_2,
    input  logic                  Read_Enable_2,
    output logic [DATA_WIDTH-1:0] Read_Data_1,
    output logic [DATA_WIDTH-1:0] Read_Data_2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_wr_ok;
    logic [DATA_WIDTH-1:0] w_rv1;
    logic [DATA_WIDTH-1:0] w_rv2;

    // Effective read value: zero word first, then same-cycle forwarding, then storage.
    function automatic logic [DATA_WIDTH-1:0] f_read_value(
        input logic [ADDR_WIDTH-1:0] ra,
        input logic [DATA_WIDTH-1:0] mem_word,
        input logic                  we,
        input logic [ADDR_WIDTH-1:0] wa,
        input logic [DATA_WIDTH-1:0] wd
    );
        if (ZERO_REG != 0 && ra == '0)
            return '0;
        else if (BYPASS != 0 && we && wa == ra)
            return wd;
        else
            return mem_word;
    endfunction

    assign w_wr_ok = Write_Enable && !(ZERO_REG != 0 && Write_Address == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_wr_ok) begin
            r_mem[Write_Address] <= Write_Data;
        end
    end

    always_comb begin
        w_rv1 = f_read_value(Read_Address_1, r_mem[Read_Address_1],
                             Write_Enable, Write_Address, Write_Data);
        w_rv2 = f_read_value(Read_Address_2, r_mem[Read_Address_2],
                             Write_Enable, Write_Address, Write_Data);
    end

    generate
        if (READ_REG != 0) begin : g_rreg
            logic [DATA_WIDTH-1:0] r_rd1;
            logic [DATA_WIDTH-1:0] r_rd2;

            // Each port captures only on its own enable; reset overrides captures.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rd1 <= '0;
                    r_rd2 <= '0;
                end else begin
                    if (Read_Enable_1)
                        r_rd1 <= w_rv1;
                    if (Read_Enable_2)
                        r_rd2 <= w_rv2;
                end
            end

            assign Read_Data_1 = r_rd1;
            assign Read_Data_2 = r_rd2;
        end else begin : g_comb
            logic w_unused_ren;

            assign w_unused_ren = Read_Enable_1 ^ Read_Enable_2;
            assign Read_Data_1  = w_rv1;
            assign Read_Data_2  = w_rv2;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w across several parameter configurations
// sharing one clock and reset.
module tb_regfile_2r1w;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] wd = '0;
    logic [2:0] wa = '0;
    logic       we = 1'b0;
    logic [2:0] ra1 = '0;
    logic       re1 = 1'b0;
    logic [2:0] ra2 = '0;
    logic       re2 = 1'b0;

    logic [7:0] d_rd1, d_rd2, nb_rd1, nb_rd2, rr_rd1, rr_rd2, rn_rd1, rn_rd2, zr_rd1, zr_rd2;

    logic       s1_wd = 1'b0, s1_wa = 1'b0, s1_we = 1'b0, s1_ra1 = 1'b0, s1_ra2 = 1'b0;
    logic       s1_rd1, s1_rd2;
    logic [31:0] s32_wd = '0;
    logic [4:0]  s32_wa = '0, s32_ra1 = '0, s32_ra2 = '0;
    logic        s32_we = 1'b0, s32_re1 = 1'b0, s32_re2 = 1'b0;
    logic [31:0] s32_rd1, s32_rd2;

    logic        m1  [2];
    logic [31:0] m32 [32];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_REG(0), .BYPASS(1), .ZERO_REG(0)) u_def (
        .clk(clk), .reset(reset), .Write_Data(wd), .Write_Address(wa), .Write_Enable(we),
        .Read_Address_1(ra1), .Read_Enable_1(re1), .Read_Address_2(ra2), .Read_Enable_2(re2),
        .Read_Data_1(d_rd1), .Read_Data_2(d_rd2));
    regfile_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_REG(0), .BYPASS(0), .ZERO_REG(0)) u_nbp (
        .clk(clk), .reset(reset), .Write_Data(wd), .Write_Address(wa), .Write_Enable(we),
        .Read_Address_1(ra1), .Read_Enable_1(re1), .Read_Address_2(ra2), .Read_Enable_2(re2),
        .Read_Data_1(nb_rd1), .Read_Data_2(nb_rd2));
    regfile_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_REG(1), .BYPASS(1), .ZERO_REG(0)) u_rr (
        .clk(clk), .reset(reset), .Write_Data(wd), .Write_Address(wa), .Write_Enable(we),
        .Read_Address_1(ra1), .Read_Enable_1(re1), .Read_Address_2(ra2), .Read_Enable_2(re2),
        .Read_Data_1(rr_rd1), .Read_Data_2(rr_rd2));
    regfile_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_REG(1), .BYPASS(0), .ZERO_REG(0)) u_rrnb (
        .clk(clk), .reset(reset), .Write_Data(wd), .Write_Address(wa), .Write_Enable(we),
        .Read_Address_1(ra1), .Read_Enable_1(re1), .Read_Address_2(ra2), .Read_Enable_2(re2),
        .Read_Data_1(rn_rd1), .Read_Data_2(rn_rd2));
    regfile_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_REG(0), .BYPASS(1), .ZERO_REG(1)) u_zr (
        .clk(clk), .reset(reset), .Write_Data(wd), .Write_Address(wa), .Write_Enable(we),
        .Read_Address_1(ra1), .Read_Enable_1(re1), .Read_Address_2(ra2), .Read_Enable_2(re2),
        .Read_Data_1(zr_rd1), .Read_Data_2(zr_rd2));
    regfile_2r1w #(.DATA_WIDTH(1), .ADDR_WIDTH(1), .READ_REG(0), .BYPASS(1), .ZERO_REG(0)) u_s1 (
        .clk(clk), .reset(reset), .Write_Data(s1_wd), .Write_Address(s1_wa), .Write_Enable(s1_we),
        .Read_Address_1(s1_ra1), .Read_Enable_1(1'b0), .Read_Address_2(s1_ra2), .Read_Enable_2(1'b0),
        .Read_Data_1(s1_rd1), .Read_Data_2(s1_rd2));
    regfile_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_REG(1), .BYPASS(0), .ZERO_REG(0)) u_s32 (
        .clk(clk), .reset(reset), .Write_Data(s32_wd), .Write_Address(s32_wa), .Write_Enable(s32_we),
        .Read_Address_1(s32_ra1), .Read_Enable_1(s32_re1), .Read_Address_2(s32_ra2), .Read_Enable_2(s32_re2),
        .Read_Data_1(s32_rd1), .Read_Data_2(s32_rd2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        we = 1'b1; wa = a; wd = d;
        step();
        we = 1'b0;
    endtask

    task automatic test_reset();
        ra1 = 3'd0; ra2 = 3'd7;
        @(negedge clk);
        checks++; if (d_rd1 !== 8'h00 || d_rd2 !== 8'h00) begin failures++;
            $display("FAIL reset_comb got=%h/%h exp=00/00", d_rd1, d_rd2); end
        checks++; if (rr_rd1 !== 8'h00 || rr_rd2 !== 8'h00) begin failures++;
            $display("FAIL reset_reg got=%h/%h exp=00/00", rr_rd1, rr_rd2); end
        checks++; if (zr_rd1 !== 8'h00 || nb_rd2 !== 8'h00) begin failures++;
            $display("FAIL reset_misc got=%h/%h exp=00/00", zr_rd1, nb_rd2); end
        step();
    endtask

    task automatic test_basic();
        wr(3'd3, 8'hA5);
        wr(3'd6, 8'h5A);
        ra1 = 3'd3; ra2 = 3'd6; re1 = 1'b1; re2 = 1'b1;
        @(negedge clk);
        checks++; if (d_rd1 !== 8'hA5 || d_rd2 !== 8'h5A) begin failures++;
            $display("FAIL basic_read got=%h/%h exp=a5/5a", d_rd1, d_rd2); end
        step();
        re1 = 1'b0; re2 = 1'b0;
        @(negedge clk);
        checks++; if (rr_rd1 !== 8'hA5 || rr_rd2 !== 8'h5A) begin failures++;
            $display("FAIL basic_regread got=%h/%h exp=a5/5a", rr_rd1, rr_rd2); end
        ra1 = 3'd1;
        #1;
        checks++; if (d_rd1 !== 8'h00) begin failures++;
            $display("FAIL basic_unwritten got=%h exp=00", d_rd1); end
        step();
    endtask

    task automatic test_bypass();
        wr(3'd2, 8'h11);
        we = 1'b1; wa = 3'd2; wd = 8'h22;
        ra1 = 3'd2; ra2 = 3'd2; re1 = 1'b1; re2 = 1'b1;
        @(negedge clk);
        checks++; if (d_rd1 !== 8'h22 || d_rd2 !== 8'h22) begin failures++;
            $display("FAIL bypass_on got=%h/%h exp=22/22", d_rd1, d_rd2); end
        checks++; if (nb_rd1 !== 8'h11 || nb_rd2 !== 8'h11) begin failures++;
            $display("FAIL bypass_off_same got=%h/%h exp=11/11", nb_rd1, nb_rd2); end
        step();
        we = 1'b0; re1 = 1'b0; re2 = 1'b0;
        @(negedge clk);
        checks++; if (nb_rd1 !== 8'h22 || nb_rd2 !== 8'h22) begin failures++;
            $display("FAIL bypass_off_next got=%h/%h exp=22/22", nb_rd1, nb_rd2); end
        checks++; if (rr_rd1 !== 8'h22 || rr_rd2 !== 8'h22) begin failures++;
            $display("FAIL bypass_reg_on got=%h/%h exp=22/22", rr_rd1, rr_rd2); end
        checks++; if (rn_rd1 !== 8'h11 || rn_rd2 !== 8'h11) begin failures++;
            $display("FAIL bypass_reg_off got=%h/%h exp=11/11", rn_rd1, rn_rd2); end
        step();
    endtask

    task automatic test_regread();
        wr(3'd4, 8'h3C);
        ra1 = 3'd4; ra2 = 3'd4; re1 = 1'b1; re2 = 1'b0;
        @(negedge clk);
        checks++; if (rr_rd1 !== 8'h22) begin failures++;
            $display("FAIL regread_latency got=%h exp=22", rr_rd1); end
        step();
        re1 = 1'b0;
        @(negedge clk);
        checks++; if (rr_rd1 !== 8'h3C || rr_rd2 !== 8'h22) begin failures++;
            $display("FAIL regread_capture got=%h/%h exp=3c/22", rr_rd1, rr_rd2); end
        ra1 = 3'd6;
        step();
        @(negedge clk);
        checks++; if (rr_rd1 !== 8'h3C) begin failures++;
            $display("FAIL regread_hold got=%h exp=3c", rr_rd1); end
        ra2 = 3'd6; re2 = 1'b1;
        step();
        re2 = 1'b0;
        @(negedge clk);
        checks++; if (rr_rd2 !== 8'h5A || rr_rd1 !== 8'h3C) begin failures++;
            $display("FAIL regread_port2 got=%h/%h exp=5a/3c", rr_rd2, rr_rd1); end
        step();
    endtask

    task automatic test_zero();
        ra1 = 3'd0; ra2 = 3'd0;
        we = 1'b1; wa = 3'd0; wd = 8'hFF;
        @(negedge clk);
        checks++; if (zr_rd1 !== 8'h00 || zr_rd2 !== 8'h00) begin failures++;
            $display("FAIL zero_bypass got=%h/%h exp=00/00", zr_rd1, zr_rd2); end
        checks++; if (d_rd1 !== 8'hFF) begin failures++;
            $display("FAIL zero_nonzero_cfg got=%h exp=ff", d_rd1); end
        step();
        we = 1'b0;
        @(negedge clk);
        checks++; if (zr_rd1 !== 8'h00 || d_rd2 !== 8'hFF) begin failures++;
            $display("FAIL zero_after got=%h/%h exp=00/ff", zr_rd1, d_rd2); end
        ra1 = 3'd1; we = 1'b1; wa = 3'd1; wd = 8'h42;
        @(negedge clk);
        checks++; if (zr_rd1 !== 8'h42) begin failures++;
            $display("FAIL zero_addr1_bypass got=%h exp=42", zr_rd1); end
        step();
        we = 1'b0;
        @(negedge clk);
        checks++; if (zr_rd1 !== 8'h42) begin failures++;
            $display("FAIL zero_addr1_stored got=%h exp=42", zr_rd1); end
        step();
    endtask

    task automatic test_reset_priority();
        ra1 = 3'd5; ra2 = 3'd5; re1 = 1'b1; re2 = 1'b1;
        we = 1'b1; wa = 3'd5; wd = 8'h77; reset = 1'b1;
        step();
        reset = 1'b0; we = 1'b0; re1 = 1'b0; re2 = 1'b0;
        @(negedge clk);
        checks++; if (d_rd1 !== 8'h00 || nb_rd2 !== 8'h00) begin failures++;
            $display("FAIL rstpri_mem got=%h/%h exp=00/00", d_rd1, nb_rd2); end
        checks++; if (rr_rd1 !== 8'h00 || rr_rd2 !== 8'h00) begin failures++;
            $display("FAIL rstpri_reg got=%h/%h exp=00/00", rr_rd1, rr_rd2); end
        ra1 = 3'd3; ra2 = 3'd6;
        #1;
        checks++; if (d_rd1 !== 8'h00 || d_rd2 !== 8'h00) begin failures++;
            $display("FAIL rstpri_cleared got=%h/%h exp=00/00", d_rd1, d_rd2); end
        step();
        wr(3'd5, 8'h77);
        ra1 = 3'd5; re1 = 1'b1;
        step();
        re1 = 1'b0;
        @(negedge clk);
        checks++; if (d_rd1 !== 8'h77 || rr_rd1 !== 8'h77) begin failures++;
            $display("FAIL rstpri_resume got=%h/%h exp=77/77", d_rd1, rr_rd1); end
        step();
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 32; i++) begin
            s32_we = 1'b1; s32_wa = 5'(i); s32_wd = $urandom; m32[i] = s32_wd;
            if (i < 2) begin
                s1_we = 1'b1; s1_wa = 1'(i); s1_wd = 1'($urandom); m1[i] = s1_wd;
            end else begin
                s1_we = 1'b0;
            end
            step();
        end
        s32_we = 1'b0; s1_we = 1'b0;
        for (int k = 0; k < 24; k++) begin
            s32_ra1 = 5'($urandom_range(0, 31)); s32_ra2 = 5'($urandom_range(0, 31));
            s32_re1 = 1'b1; s32_re2 = 1'b1;
            s1_ra1 = 1'($urandom_range(0, 1)); s1_ra2 = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++; if (s1_rd1 !== m1[s1_ra1] || s1_rd2 !== m1[s1_ra2]) begin failures++;
                $display("FAIL sweep_w1 addr=%0d/%0d got=%b/%b exp=%b/%b", s1_ra1, s1_ra2,
                         s1_rd1, s1_rd2, m1[s1_ra1], m1[s1_ra2]); end
            step();
            @(negedge clk);
            checks++; if (s32_rd1 !== m32[s32_ra1] || s32_rd2 !== m32[s32_ra2]) begin failures++;
                $display("FAIL sweep_w32 addr=%0d/%0d got=%h/%h exp=%h/%h", s32_ra1, s32_ra2,
                         s32_rd1, s32_rd2, m32[s32_ra1], m32[s32_ra2]); end
        end
        s32_re1 = 1'b0; s32_re2 = 1'b0;
        step();
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_basic();
        test_bypass();
        test_regread();
        test_zero();
        test_reset_priority();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
